// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller.
// Orders halt, data wait, branch, load-use and fetch miss.
module pipeline_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       mem_dren,
  input  logic       mem_dwen,
  input  logic       mem_branch_taken,
  input  logic       mem_halt,
  input  logic       ex_dren,
  input  logic [4:0] ex_wsel,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       exmem_flush,
  output logic       memwb_en,
  output logic       halt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   lu, dp, br_act;

  assign lu = ex_dren & (ex_wsel != 5'd0) &
              ((ex_wsel == id_rs) |
               (id_uses_rt & (ex_wsel == id_rt)));

  assign dp = (mem_dren | mem_dwen) & ~dhit;

  // halt is the decoded state flop, so it is registered
  assign halt = (state == HALT);

  // Next state and stage enables/flushes by priority
  always_comb begin
    state_nx    = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    br_act      = 1'b0;
    if (RST) begin
      state_nx = RUN;
    end else if (state == HALT) begin
      state_nx = HALT;
    end else if (mem_halt) begin
      exmem_en    = 1'b1;
      exmem_flush = 1'b1;
      memwb_en    = 1'b1;
      state_nx    = HALT;
    end else if (dp) begin
      state_nx = DWAIT;
    end else begin
      state_nx = RUN;
      if (mem_branch_taken) begin
        br_act      = 1'b1;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
      end else if (lu) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nx;
  end

  // Saturating count of frozen-PC cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stall_cnt <= 16'd0;
    else if (!pc_en && state != HALT &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  // Saturating count of taken-branch redirects
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      flush_cnt <= 16'd0;
    else if (br_act && flush_cnt != 16'hFFFF)
      flush_cnt <= flush_cnt + 16'd1;
  end

endmodule
